inst_prefetch_queue: RTL and testbench

Instruction prefetch unit upstream of fetch_stage. Issues sequential word fetches to an instruction memory with a valid/ready request channel and in-order responses, and buffers the returned instructions in a DEPTH-entry FIFO. Presents {pc, inst, fault} to the decode side with a valid/ready handshake. A jump/branch redirect from execute flushes the queue and restarts fetching at the new address.

---
 rtl/inst_prefetch_queue.sv | 173 +++++++++++++++++
 tb/tb_inst_prefetch_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetcher. It issues in-order word fetches under a credit limit
// and buffers the responses in a DEPTH-entry FIFO that feeds decode.
module inst_prefetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enq,
  input  logic          deq,
  input  logic [CW-1:0] count
);
  // The credit scheme must make it impossible to enqueue into a full FIFO without a dequeue.
  overflow_a: assert property (@(posedge clock) disable iff (reset)
    !(enq && !deq && (count == CW'(DEPTH))))
    else $error("inst_prefetch_queue FIFO overflow");
endmodule

module inst_prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            imem_resp_fault,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic            inst_fault,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr
);
  localparam int              PW       = $clog2(DEPTH);
  localparam int              CW       = PW + 1;
  localparam int              SW       = CW + 1;
  localparam logic [SW-1:0]   DEPTH_S  = SW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(3'd4);
  localparam logic [PW-1:0]   PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);

  logic [XLEN-1:0]  fetch_pc_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    outstanding_r;
  logic [CW-1:0]    drop_r;
  logic             halted_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    aw_ptr_r;
  logic [PW-1:0]    ar_ptr_r;
  logic [XLEN-1:0]  pc_mem_r   [DEPTH];
  logic [ILEN-1:0]  inst_mem_r [DEPTH];
  logic [XLEN-1:0]  addr_mem_r [DEPTH];
  logic [DEPTH-1:0] fault_mem_r;

  logic req_valid_s;
  logic fire_s;
  logic resp_s;
  logic enq_s;
  logic deq_s;
  logic misaligned_s;

  // Credit check and the handshake events of the current cycle.
  always_comb begin
    req_valid_s  = 1'b0;
    misaligned_s = (redirect_addr[1:0] != 2'b00);
    if (!reset && !halted_r && !redirect &&
        ((SW'(count_r) + SW'(outstanding_r)) < DEPTH_S)) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    fire_s = req_valid_s && imem_req_ready;
    // A response with nothing outstanding can only be a leftover from before reset.
    resp_s = imem_resp_valid && (outstanding_r != CNT_ZERO);
    enq_s  = resp_s && (drop_r == CNT_ZERO) && !redirect;
    deq_s  = (count_r != CNT_ZERO) && inst_ready;
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;
  assign inst_valid     = (count_r != CNT_ZERO);
  assign inst           = inst_mem_r[rd_ptr_r];
  assign pc             = pc_mem_r[rd_ptr_r];
  assign inst_fault     = fault_mem_r[rd_ptr_r];

  // Fetch pointer, credit counters, request-address FIFO and instruction FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      count_r       <= CNT_ZERO;
      outstanding_r <= CNT_ZERO;
      drop_r        <= CNT_ZERO;
      halted_r      <= 1'b0;
      rd_ptr_r      <= PTR_ZERO;
      wr_ptr_r      <= PTR_ZERO;
      aw_ptr_r      <= PTR_ZERO;
      ar_ptr_r      <= PTR_ZERO;
      fault_mem_r   <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= RESET_PC;
        inst_mem_r[i] <= {ILEN{1'b0}};
        addr_mem_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      if (fire_s) begin
        addr_mem_r[aw_ptr_r] <= fetch_pc_r;
        aw_ptr_r             <= aw_ptr_r + PTR_ONE;
      end
      if (resp_s) begin
        ar_ptr_r <= ar_ptr_r + PTR_ONE;
      end
      outstanding_r <= outstanding_r + CW'(fire_s) - CW'(resp_s);
      if (redirect) begin
        // Everything still in flight belongs to the old path and must be discarded.
        fetch_pc_r <= redirect_addr;
        drop_r     <= outstanding_r - CW'(resp_s);
        halted_r   <= misaligned_s;
        rd_ptr_r   <= PTR_ZERO;
        if (misaligned_s) begin
          pc_mem_r[PTR_ZERO]    <= redirect_addr;
          inst_mem_r[PTR_ZERO]  <= {ILEN{1'b0}};
          fault_mem_r[PTR_ZERO] <= 1'b1;
          wr_ptr_r              <= PTR_ONE;
          count_r               <= CNT_ONE;
        end else begin
          wr_ptr_r <= PTR_ZERO;
          count_r  <= CNT_ZERO;
        end
      end else begin
        if (fire_s) begin
          fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
        if (resp_s && (drop_r != CNT_ZERO)) begin
          drop_r <= drop_r - CNT_ONE;
        end
        if (enq_s) begin
          pc_mem_r[wr_ptr_r]    <= addr_mem_r[ar_ptr_r];
          inst_mem_r[wr_ptr_r]  <= imem_resp_data;
          fault_mem_r[wr_ptr_r] <= imem_resp_fault;
          wr_ptr_r              <= wr_ptr_r + PTR_ONE;
          if (imem_resp_fault) begin
            halted_r <= 1'b1;
          end
        end
        if (deq_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        count_r <= count_r + CW'(enq_s) - CW'(deq_s);
      end
    end
  end

  inst_prefetch_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clock (clock),
    .reset (reset),
    .enq   (enq_s),
    .deq   (deq_s),
    .count (count_r)
  );
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: an in-order memory model plus an epoch-tagged reference
// queue that predicts the request channel and the decode-side stream every cycle.
module tb_inst_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NO_FAULT = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        imem_resp_fault = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_fault;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = 32'h0;

  inst_prefetch_queue #(
    .XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_fault(imem_resp_fault),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .inst_fault(inst_fault),
    .redirect(redirect), .redirect_addr(redirect_addr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  req_t        pending[$];
  ent_t        exp_q[$];
  int          epoch, cyc, lat, ready_pct, resp_pct, fault_pct, fires;
  int          checks, failures;
  logic [31:0] mpc, fault_addr, n_raddr;
  logic        m_halted, n_redirect, n_inst_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1ns later, advance the model.
  task automatic cycle();
    req_t r;
    req_t nr;
    ent_t e;
    ent_t junk;
    logic erv, fire, deq, rsp;
    @(negedge clock);
    redirect       = n_redirect;
    redirect_addr  = n_raddr;
    inst_ready     = n_inst_ready;
    imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    rsp = (pending.size() > 0) && ($urandom_range(0, 99) < resp_pct);
    if (rsp && (pending[0].due > cyc)) rsp = 1'b0;
    imem_resp_valid = rsp;
    if (rsp) begin
      imem_resp_data  = pending[0].data;
      imem_resp_fault = pending[0].fault;
    end else begin
      imem_resp_data  = 32'h0;
      imem_resp_fault = 1'b0;
    end
    #1;
    erv = !m_halted && !n_redirect && ((exp_q.size() + pending.size()) < DEPTH);
    chk("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("pc", 64'(pc), 64'(exp_q[0].pc));
      chk("inst", 64'(inst), 64'(exp_q[0].inst));
      chk("inst_fault", 64'(inst_fault), 64'(exp_q[0].fault));
    end
    chk("req_valid", 64'(imem_req_valid), 64'(erv));
    if (erv) chk("req_addr", 64'(imem_req_addr), 64'(mpc));
    if (imem_req_valid && imem_req_ready) fires++;
    fire = erv && imem_req_ready;
    deq  = (exp_q.size() != 0) && n_inst_ready;
    if (rsp) r = pending.pop_front();
    if (n_redirect) begin
      exp_q.delete();
      epoch++;
      mpc      = n_raddr;
      m_halted = (n_raddr[1:0] != 2'b00);
      if (m_halted) begin
        e.pc = n_raddr; e.inst = 32'h0; e.fault = 1'b1;
        exp_q.push_back(e);
      end
    end else begin
      if (deq) junk = exp_q.pop_front();
      if (rsp && (r.epoch == epoch)) begin
        e.pc = r.addr; e.inst = r.data; e.fault = r.fault;
        exp_q.push_back(e);
        if (r.fault) m_halted = 1'b1;
      end
      if (fire) begin
        nr.addr  = mpc;
        nr.data  = $urandom;
        nr.fault = (mpc == fault_addr) || ($urandom_range(0, 99) < fault_pct);
        nr.epoch = epoch;
        nr.due   = cyc + lat;
        pending.push_back(nr);
        mpc = mpc + 32'd4;
      end
    end
    cyc++;
    n_redirect = 1'b0;
  endtask

  // Asynchronous reset in the middle of a cycle; a stray response follows the release.
  task automatic do_reset();
    @(negedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_inst_valid", 64'(inst_valid), 64'(1'b0));
    chk("rst_req_valid", 64'(imem_req_valid), 64'(1'b0));
    chk("rst_inst", 64'(inst), 64'(32'h0));
    chk("rst_pc", 64'(pc), 64'(RESET_PC));
    chk("rst_inst_fault", 64'(inst_fault), 64'(1'b0));
    pending.delete();
    exp_q.delete();
    mpc      = RESET_PC;
    m_halted = 1'b0;
    epoch++;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    redirect        = 1'b0;
    inst_ready      = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset           = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    imem_resp_fault = 1'b0;
    fires = 0;
  endtask

  initial begin
    checks = 0; failures = 0; epoch = 0; cyc = 0; fires = 0;
    lat = 1; ready_pct = 100; resp_pct = 100; fault_pct = 0;
    fault_addr = NO_FAULT; mpc = RESET_PC; m_halted = 1'b0;
    n_redirect = 1'b0; n_raddr = 32'h0; n_inst_ready = 1'b1;

    // Streaming with a one-cycle memory and decode always ready.
    do_reset();
    repeat (12) cycle();

    // Decode stalled: the credit limit allows exactly DEPTH requests.
    do_reset();
    n_inst_ready = 1'b0;
    repeat (10) cycle();
    chk("stall_fires", 64'(fires), 64'(4));
    n_inst_ready = 1'b1;
    repeat (12) cycle();

    // Three requests in flight when a redirect arrives.
    do_reset();
    lat = 4;
    repeat (3) cycle();
    chk("inflight_fires", 64'(fires), 64'(3));
    n_redirect = 1'b1; n_raddr = 32'h0000_0100;
    cycle();
    lat = 1;
    repeat (15) cycle();

    // Access fault on 0x8 halts fetching until a redirect to 0x40.
    do_reset();
    fault_addr = 32'h0000_0008;
    repeat (12) cycle();
    chk("fault_fires", 64'(fires), 64'(4));
    fault_addr = NO_FAULT;
    n_redirect = 1'b1; n_raddr = 32'h0000_0040;
    repeat (10) cycle();

    // Misaligned redirect yields one faulting entry and no requests.
    n_redirect = 1'b1; n_raddr = 32'h0000_0102;
    fires = 0;
    cycle();
    n_inst_ready = 1'b0;
    repeat (4) cycle();
    chk("misalign_fires", 64'(fires), 64'(0));
    n_inst_ready = 1'b1;
    repeat (2) cycle();

    // Fetch address wraps at the top of the address space.
    n_redirect = 1'b1; n_raddr = 32'hFFFF_FFF8;
    repeat (8) cycle();

    // Reset while requests are outstanding.
    lat = 3;
    repeat (4) cycle();
    do_reset();
    lat = 1;
    repeat (8) cycle();

    // Randomised traffic with redirects, faults, stalls and variable latency.
    fault_pct = 3; ready_pct = 70; resp_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 4);
      n_inst_ready = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 3) begin
        n_redirect = 1'b1;
        n_raddr = $urandom & 32'h0000_0FFC;
        if ($urandom_range(0, 3) == 0) n_raddr[1:0] = 2'($urandom_range(1, 3));
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
